if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined MIPS core. It owns the program counter and the instruction-memory address, and it produces `pcAdd4IF` and `instructionIF` for the IF/ID pipeline register. It honours the same one-shot hold protocol that register implements, so PC and IF/ID always stall on the same edges. It also applies branch and jump redirects resolved in ID, squashes the wrong-path instruction, and halts on a halt word.

---
 rtl/if_fetch_stage_pkg.sv | 15 +
 rtl/if_fetch_stage_sat_counter16.sv | 18 +
 rtl/if_fetch_stage.sv | 104 ++++++++++
 tb/tb_if_fetch_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD      = 32'b0;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_stage_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rstN,
  input  logic        en,
  output logic [15:0] count
);

  // Increment on enabled edges until the count saturates.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, applies ID-stage redirects,
// squashes the wrong-path slot, follows the IF/ID one-shot hold and halts.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        hold,
  input  logic        branchTakenID,
  input  logic [31:0] branchTargetID,
  input  logic        jumpID,
  input  logic [31:0] jumpTargetID,
  input  logic [31:0] imemData,
  output logic [31:0] imemAddr,
  output logic [31:0] pcAdd4IF,
  output logic [31:0] instructionIF,
  output logic        halted,
  output logic [15:0] fetchCount,
  output logic [15:0] stallCount
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next, pc_target;
  logic         advance, redirect, squash, fetch_inc, stall_inc;

  assign redirect = jumpID | branchTakenID;

  // Next-PC candidate: jump beats branch beats sequential; targets word-aligned.
  always_comb begin
    pc_target = pc + 32'd4;
    if (jumpID) begin
      pc_target = jumpTargetID & ALIGN_MASK;
    end else if (branchTakenID) begin
      pc_target = branchTargetID & ALIGN_MASK;
    end
  end

  // Next-state logic; a STALL edge always advances, mirroring the IF/ID one-shot flag.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    advance    = 1'b0;
    squash     = 1'b0;
    fetch_inc  = 1'b0;
    stall_inc  = 1'b0;
    case (state)
      RUN: begin
        if (hold) begin
          state_next = STALL;
          stall_inc  = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      STALL:   advance = 1'b1;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
    if (advance) begin
      if (!redirect && (imemData == HALT_WORD)) begin
        state_next = HALT;
      end else begin
        state_next = RUN;
        pc_next    = pc_target;
        fetch_inc  = 1'b1;
        squash     = redirect;
      end
    end
  end

  // PC and state registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  assign imemAddr      = pc;
  assign pcAdd4IF      = pc + 32'd4;
  assign halted        = (state == HALT);
  assign instructionIF = (!rstN || halted || squash) ? NOP_WORD : imemData;

  sat_counter16 u_fetch_cnt (
    .clk   (clk),
    .rstN  (rstN),
    .en    (fetch_inc),
    .count (fetchCount)
  );

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rstN  (rstN),
    .en    (stall_inc),
    .count (stallCount)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage against a behavioural fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] HW     = 32'hFFFF_FFFF;
  localparam logic [31:0] INSN   = 32'h2008_0001;

  logic        clk, rstN, hold, branchTakenID, jumpID;
  logic [31:0] branchTargetID, jumpTargetID, imemData;
  logic [31:0] imemAddr, pcAdd4IF, instructionIF;
  logic        halted;
  logic [15:0] fetchCount, stallCount;

  if_fetch_stage #(.RESET_PC(RST_PC), .HALT_WORD(HW)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .hold           (hold),
    .branchTakenID  (branchTakenID),
    .branchTargetID (branchTargetID),
    .jumpID         (jumpID),
    .jumpTargetID   (jumpTargetID),
    .imemData       (imemData),
    .imemAddr       (imemAddr),
    .pcAdd4IF       (pcAdd4IF),
    .instructionIF  (instructionIF),
    .halted         (halted),
    .fetchCount     (fetchCount),
    .stallCount     (stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: PC, "previous edge was a honoured hold", halted flag, counts.
  logic [31:0] m_pc;
  bit          m_held, m_halted;
  int unsigned m_fc, m_sc;

  logic [31:0] exp_addr, exp_p4, exp_instr;
  logic        exp_halted;
  logic [15:0] exp_fc, exp_sc;

  function automatic void model_reset();
    m_pc = RST_PC; m_held = 0; m_halted = 0; m_fc = 0; m_sc = 0;
  endfunction

  // Apply one cycle's inputs and derive the expected combinational outputs.
  task automatic drive(input bit h, input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input logic [31:0] d);
    bit honoured;
    hold = h; branchTakenID = b; branchTargetID = bt;
    jumpID = j; jumpTargetID = jt; imemData = d;
    #1;
    honoured   = !m_halted && !m_held && h;
    exp_addr   = m_pc;
    exp_p4     = m_pc + 32'd4;
    exp_halted = m_halted;
    exp_fc     = (m_fc > 65535) ? 16'hFFFF : m_fc[15:0];
    exp_sc     = (m_sc > 65535) ? 16'hFFFF : m_sc[15:0];
    exp_instr  = (m_halted || (!honoured && (b || j))) ? 32'h0 : d;
  endtask

  // Clock edge: advance the model from the inputs in force at the edge.
  task automatic tick();
    @(posedge clk);
    if (!m_halted) begin
      if (!m_held && hold) begin
        m_held = 1;
        if (m_sc < 65535) m_sc++;
      end else begin
        m_held = 0;
        if (jumpID) m_pc = {jumpTargetID[31:2], 2'b00};
        else if (branchTakenID) m_pc = {branchTargetID[31:2], 2'b00};
        else if (imemData == HW) m_halted = 1;
        else m_pc = m_pc + 32'd4;
        if (!m_halted && m_fc < 65535) m_fc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rstN = 1'b0;
    model_reset();
    #2;
    rstN = 1'b1;
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, '0, 0, '0, INSN);
      tick();
    end
  endtask

  task automatic test_reset();
    imemData = 32'h1234_5678; hold = 0; branchTakenID = 0; jumpID = 0;
    branchTargetID = '0; jumpTargetID = '0;
    rstN = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({imemAddr, instructionIF, halted, fetchCount, stallCount} !== {RST_PC, 32'h0, 1'b0, 16'h0, 16'h0}) begin
      fails++;
      $display("FAIL reset: got addr=%h ins=%h h=%b fc=%0d sc=%0d, expected addr=%h ins=0 h=0 fc=0 sc=0",
               imemAddr, instructionIF, halted, fetchCount, stallCount, RST_PC);
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, 0, '0, INSN);
      tests++;
      if ({imemAddr, pcAdd4IF, instructionIF, halted, fetchCount} !==
          {32'(i * 4), 32'(i * 4 + 4), INSN, 1'b0, 16'(i)}) begin
        fails++;
        $display("FAIL seq[%0d]: got addr=%h p4=%h ins=%h h=%b fc=%0d, expected addr=%h fc=%0d",
                 i, imemAddr, pcAdd4IF, instructionIF, halted, fetchCount, i * 4, i);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [31:0] a1 [5] = '{0, 4, 8, 8, 12};
    bit          h1 [5] = '{0, 0, 1, 0, 0};
    logic [31:0] a2 [7] = '{0, 4, 8, 8, 12, 12, 16};
    bit          h2 [7] = '{0, 0, 1, 1, 1, 1, 0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(h1[i], 0, '0, 0, '0, INSN);
      tests++;
      if (imemAddr !== a1[i] || stallCount !== exp_sc) begin
        fails++;
        $display("FAIL hold1[%0d]: got addr=%h sc=%0d, expected addr=%h sc=%0d", i, imemAddr, stallCount, a1[i], exp_sc);
      end
      tick();
    end
    tests++;
    if (stallCount !== 16'd1) begin
      fails++;
      $display("FAIL hold1_count: got %0d expected 1", stallCount);
    end
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(h2[i], 0, '0, 0, '0, INSN);
      tests++;
      if (imemAddr !== a2[i] || fetchCount !== exp_fc) begin
        fails++;
        $display("FAIL hold4[%0d]: got addr=%h fc=%0d, expected addr=%h fc=%0d", i, imemAddr, fetchCount, a2[i], exp_fc);
      end
      tick();
    end
    tests++;
    if (stallCount !== 16'd2) begin
      fails++;
      $display("FAIL hold4_count: got %0d expected 2", stallCount);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    run_seq(4);
    drive(0, 1, 32'h0000_0041, 0, '0, INSN);
    tests++;
    if (imemAddr !== 32'd16 || instructionIF !== 32'h0) begin
      fails++;
      $display("FAIL branch_squash: got addr=%h ins=%h, expected addr=00000010 ins=00000000", imemAddr, instructionIF);
    end
    tick();
    drive(0, 1, 32'h0000_0200, 1, 32'h0000_0103, INSN);
    tests++;
    if (imemAddr !== 32'h40 || instructionIF !== 32'h0) begin
      fails++;
      $display("FAIL branch_target: got addr=%h ins=%h, expected addr=00000040 ins=00000000", imemAddr, instructionIF);
    end
    tick();
    drive(0, 0, '0, 0, '0, INSN);
    tests++;
    if (imemAddr !== 32'h100 || instructionIF !== INSN || fetchCount !== exp_fc) begin
      fails++;
      $display("FAIL jump_priority: got addr=%h ins=%h fc=%0d, expected addr=00000100 ins=%h fc=%0d",
               imemAddr, instructionIF, fetchCount, INSN, exp_fc);
    end
    tick();
  endtask

  task automatic test_hold_branch();
    apply_reset();
    run_seq(2);
    drive(1, 1, 32'h0000_0080, 0, '0, INSN);
    tests++;
    if (instructionIF !== INSN) begin
      fails++;
      $display("FAIL hold_branch_nosquash: got ins=%h expected %h", instructionIF, INSN);
    end
    tick();
    drive(1, 1, 32'h0000_0080, 0, '0, INSN);
    tests++;
    if (imemAddr !== 32'd8 || instructionIF !== 32'h0) begin
      fails++;
      $display("FAIL stall_branch: got addr=%h ins=%h, expected addr=00000008 ins=00000000", imemAddr, instructionIF);
    end
    tick();
    drive(0, 0, '0, 0, '0, INSN);
    tests++;
    if (imemAddr !== 32'h80 || stallCount !== 16'd1) begin
      fails++;
      $display("FAIL stall_branch_target: got addr=%h sc=%0d, expected addr=00000080 sc=1", imemAddr, stallCount);
    end
    tick();
  endtask

  task automatic test_halt();
    apply_reset();
    run_seq(6);
    drive(0, 0, '0, 0, '0, HW);
    tests++;
    if (imemAddr !== 32'd24 || instructionIF !== HW || halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_word_fetch: got addr=%h ins=%h h=%b, expected addr=00000018 ins=%h h=0", imemAddr, instructionIF, halted, HW);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom);
      tests++;
      if ({halted, imemAddr, instructionIF, fetchCount, stallCount} !== {1'b1, 32'd24, 32'h0, 16'd6, 16'd0}) begin
        fails++;
        $display("FAIL halted[%0d]: got h=%b addr=%h ins=%h fc=%0d sc=%0d, expected h=1 addr=00000018 ins=0 fc=6 sc=0",
                 i, halted, imemAddr, instructionIF, fetchCount, stallCount);
      end
      tick();
    end
    apply_reset();
    run_seq(6);
    drive(0, 1, 32'h0000_0044, 0, '0, HW);
    tick();
    drive(0, 0, '0, 0, '0, INSN);
    tests++;
    if (halted !== 1'b0 || imemAddr !== 32'h44) begin
      fails++;
      $display("FAIL halt_redirect: got h=%b addr=%h, expected h=0 addr=00000044", halted, imemAddr);
    end
    tick();
  endtask

  task automatic test_reset_midstall();
    apply_reset();
    run_seq(8);
    drive(1, 1, 32'h0000_0300, 0, '0, INSN);
    tick();
    rstN = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({imemAddr, fetchCount, stallCount, instructionIF} !== {RST_PC, 16'd0, 16'd0, 32'h0}) begin
      fails++;
      $display("FAIL reset_midstall: got addr=%h fc=%0d sc=%0d ins=%h, expected addr=%h fc=0 sc=0 ins=0",
               imemAddr, fetchCount, stallCount, instructionIF, RST_PC);
    end
    #1;
    rstN = 1'b1;
    drive(0, 0, '0, 0, '0, INSN);
    tests++;
    if (imemAddr !== RST_PC || instructionIF !== INSN) begin
      fails++;
      $display("FAIL reset_no_pending: got addr=%h ins=%h, expected addr=%h ins=%h", imemAddr, instructionIF, RST_PC, INSN);
    end
    tick();
    drive(0, 0, '0, 1, 32'hFFFF_FFFE, INSN);
    tick();
    drive(0, 0, '0, 0, '0, INSN);
    tests++;
    if (imemAddr !== 32'hFFFF_FFFC || pcAdd4IF !== 32'h0) begin
      fails++;
      $display("FAIL top_pc: got addr=%h p4=%h, expected addr=fffffffc p4=00000000", imemAddr, pcAdd4IF);
    end
    tick();
    drive(0, 0, '0, 0, '0, INSN);
    tests++;
    if (imemAddr !== 32'h0) begin
      fails++;
      $display("FAIL pc_wrap: got addr=%h expected 00000000", imemAddr);
    end
    tick();
  endtask

  task automatic test_random();
    int halted_cycles = 0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom,
            ($urandom_range(0, 19) == 0) ? HW : $urandom);
      tests++;
      if ({imemAddr, pcAdd4IF, instructionIF, halted, fetchCount, stallCount} !==
          {exp_addr, exp_p4, exp_instr, exp_halted, exp_fc, exp_sc}) begin
        fails++;
        $display("FAIL random[%0d]: got addr=%h p4=%h ins=%h h=%b fc=%0d sc=%0d, expected addr=%h p4=%h ins=%h h=%b fc=%0d sc=%0d",
                 i, imemAddr, pcAdd4IF, instructionIF, halted, fetchCount, stallCount,
                 exp_addr, exp_p4, exp_instr, exp_halted, exp_fc, exp_sc);
      end
      tick();
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
      if (halted_cycles > 3) begin
        apply_reset();
        halted_cycles = 0;
      end
    end
  endtask

  initial begin
    rstN = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_hold();
    test_redirect();
    test_hold_branch();
    test_halt();
    test_reset_midstall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
